pixel_collector: RTL
====================

# pixel_collector

- Receives shaded pixel results from up to 4 parallel ray-tracing cores. Each core is driven by a ray generator with interleaved pixel ownership.
- Re-serialises the results into a single raster-order pixel stream with start-of-frame and end-of-line markers for the frame-buffer writer.
- Sits at the output end of the tracing pipeline and provides the per-core ready that paces each core's result hand-off.

## Interface
- MAX_CORES, 4: number of core input lanes.
- COLOUR_W, 24: pixel colour width (8:8:8 RGB).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a frame (honoured only in IDLE).
- op_code  in  2  active cores minus 1; latched at start.
- image_width, image_height  in  13 each  frame size in pixels; latched at start.
- in_valid  in  MAX_CORES  per-core result valid.
- in_ready  out  MAX_CORES  per-core accept; at most one bit set.
- in_index  in  32*MAX_CORES  per-core pixel index (lane c = bits [32c+31:32c]).
- in_colour  in  COLOUR_W*MAX_CORES  per-core colour.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accept.
- out_data  out  COLOUR_W  pixel colour.
- out_sof  out  1  qualifies the first pixel of the frame.
- out_eol  out  1  qualifies the last pixel of each line.
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted downstream.
- index_error  out  1  sticky; set on index mismatch, cleared at start or reset.

## Operation
- Pixel ownership:
  - Pixel p (0..W*H-1, raster order) belongs to core p mod N, where N = op_code+1.
  - Core c presents index c, c+N, c+2N, ….
- On start:
  - Latch W, H, N.
  - Clear expect_idx, x_cnt, y_cnt, core_ptr and index_error.
  - Go to RUN.
  - If W==0 or H==0, go to DONE instead (no pixels output).
- RUN:
  - in_ready[core_ptr] = 1 when the output register can load, i.e. !out_valid || out_ready. All other in_ready bits are 0.
  - On in_valid[core_ptr] && in_ready[core_ptr], the transfer loads the output register with:
    - colour from that lane;
    - out_sof = (expect_idx==0);
    - out_eol = (x_cnt==W-1).
  - The same transfer updates the counters:
    - expect_idx increments.
    - core_ptr wraps from N-1 to 0.
    - x_cnt wraps from W-1 to 0, with y_cnt incrementing on the wrap.
  - If the accepted lane's in_index != expect_idx, index_error sets. The pixel is still forwarded.
  - Lanes c ≥ N are never readied; their in_valid is ignored.
  - Accepting pixel W*H-1 moves the block to DRAIN.
- DRAIN:
  - All in_ready are 0.
  - When out_valid && out_ready, go to DONE.
- DONE:
  - frame_done = 1 for exactly one cycle.
  - Go to IDLE.
- start outside IDLE is ignored.
- reset mid-frame aborts the frame with no frame_done. Partially received results are discarded.
- Arithmetic:
  - Counters are unsigned.
  - expect_idx is 32 bits.
  - The W*H compare uses a 26-bit product.

## Timing
- Reset values:
  - All outputs 0.
  - out_data, out_sof and out_eol are 0.
  - State IDLE.
- start sampled at edge t → busy=1 from t+1. in_ready is available from t+1.
- Input accept at edge t → out_valid/out_data valid from t+1.
- Throughput is 1 pixel/cycle when out_ready is held high and the owning core is valid.
- Output hold rule: out_valid, once set, holds with stable out_data/sof/eol until out_ready.
- in_ready is combinational from out_valid/out_ready/state/core_ptr. There is no combinational path from in_valid to in_ready.
- Simultaneous output accept and input accept in one cycle: the register reloads and out_valid stays 1.
- Last output handshake at edge t → frame_done=1 during cycle t+1 → busy=0 from t+2.

## Test plan
- **Basic raster order:** W=4, H=2, op_code=1, both lanes always valid with correct indices, out_ready=1 → out_data in order p0..p7, one per cycle. out_sof on p0 only, out_eol on p3 and p7, frame_done one cycle after p7, index_error=0.
- **Backpressure:** W=3, H=3, op_code=3, out_ready toggling 1,0,0,1… → no pixel lost or duplicated. out_data stable while stalled. in_ready=0 during stall cycles.
- **Out-of-order cores:** op_code=2 with lane 2 valid before lane 0 at frame start → lane 2 not readied until pixels 0 and 1 are taken. Output order still p0,p1,p2.
- **Index mismatch:** lane 1 presents index 5 where 1 is expected → pixel forwarded and index_error=1 sticky until next start.
- **Degenerate/protocol:** start with W=0 → frame_done two cycles later with no out_valid. A start pulse while busy is ignored.
- **Reset mid-frame:** reset asserted mid-frame → next cycle all outputs 0 and state IDLE. A new start then produces a clean frame with out_sof on the first pixel.

Source files
------------

// File: rtl/pixel_collector.sv
// pixel_collector
// Gathers shaded pixels from up to MAX_CORES ray-tracing cores. Core c owns the
// pixels c, c+N, c+2N, ... of the frame. The block re-serialises them into one
// raster-order stream, marking the first pixel of the frame (sof) and the last
// pixel of each line (eol).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. ready never depends on valid in the same cycle, and a raised valid holds
// its payload steady until that transfer. The same rules apply to every input
// lane and to the output port.
module pixel_collector #(
    parameter int MAX_CORES = 4,
    parameter int COLOUR_W  = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    op_code,
    input  logic [12:0]                   image_width,
    input  logic [12:0]                   image_height,
    input  logic [MAX_CORES-1:0]          in_valid,
    output logic [MAX_CORES-1:0]          in_ready,
    input  logic [32*MAX_CORES-1:0]       in_index,
    input  logic [COLOUR_W*MAX_CORES-1:0] in_colour,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLOUR_W-1:0]           out_data,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          index_error,
    output logic [1:0]                    state_dbg
);

    // Frame states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Frame control registers
    logic [1:0]          state_q,      state_d;
    logic [12:0]         width_q,      width_d;
    logic [25:0]         total_q,      total_d;
    logic [1:0]          last_core_q,  last_core_d;
    logic [1:0]          core_ptr_q,   core_ptr_d;
    logic [31:0]         expect_idx_q, expect_idx_d;
    logic [12:0]         x_cnt_q,      x_cnt_d;
    logic [12:0]         y_cnt_q,      y_cnt_d;
    logic                idx_err_q,    idx_err_d;

    // Output register
    logic                out_valid_q,  out_valid_d;
    logic [COLOUR_W-1:0] out_data_q,   out_data_d;
    logic                out_sof_q,    out_sof_d;
    logic                out_eol_q,    out_eol_d;

    // Datapath helpers
    logic                can_load;
    logic                run_ready;
    logic                sel_valid;
    logic [31:0]         sel_index;
    logic [COLOUR_W-1:0] sel_colour;
    logic                accept;
    logic                last_pixel;
    logic                x_last;
    logic                core_last;
    logic                frame_empty;

    // The output register can take a new pixel when empty or being emptied now.
    assign can_load  = !out_valid_q || out_ready;
    assign run_ready = (state_q == ST_RUN) && can_load;
    assign accept    = run_ready && sel_valid;

    // Position tests: last pixel of the frame uses the 26-bit W*H product.
    assign last_pixel  = (expect_idx_q == {6'd0, total_q - 26'd1});
    assign x_last      = (x_cnt_q == width_q - 13'd1);
    assign core_last   = (core_ptr_q == last_core_q);
    assign frame_empty = (image_width == 13'd0) || (image_height == 13'd0);

    // Select the lane of the core that owns the next raster pixel.
    always_comb begin
        sel_valid  = 1'b0;
        sel_index  = '0;
        sel_colour = '0;
        for (int c = 0; c < MAX_CORES; c++) begin
            if (int'(core_ptr_q) == c) begin
                sel_valid  = in_valid[c];
                sel_index  = in_index[32*c +: 32];
                sel_colour = in_colour[COLOUR_W*c +: COLOUR_W];
            end
        end
    end

    // Only the owning lane is readied, and only while the output can load.
    always_comb begin
        in_ready = '0;
        for (int c = 0; c < MAX_CORES; c++) begin
            in_ready[c] = run_ready && (int'(core_ptr_q) == c);
        end
    end

    // Frame state machine: start latching, run, drain, done pulse.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        total_d     = total_q;
        last_core_d = last_core_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    width_d     = image_width;
                    total_d     = 26'(image_width) * 26'(image_height);
                    last_core_d = op_code;
                    state_d     = frame_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_pixel) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Raster counters and the sticky index check, advanced per accepted pixel.
    always_comb begin
        core_ptr_d   = core_ptr_q;
        expect_idx_d = expect_idx_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        idx_err_d    = idx_err_q;
        if ((state_q == ST_IDLE) && start) begin
            core_ptr_d   = 2'd0;
            expect_idx_d = 32'd0;
            x_cnt_d      = 13'd0;
            y_cnt_d      = 13'd0;
            idx_err_d    = 1'b0;
        end else if (accept) begin
            expect_idx_d = expect_idx_q + 32'd1;
            core_ptr_d   = core_last ? 2'd0 : core_ptr_q + 2'd1;
            if (x_last) begin
                x_cnt_d = 13'd0;
                y_cnt_d = y_cnt_q + 13'd1;
            end else begin
                x_cnt_d = x_cnt_q + 13'd1;
            end
            // A wrong index is flagged but the pixel still goes out.
            if (sel_index != expect_idx_q) begin
                idx_err_d = 1'b1;
            end
        end
    end

    // Output register: load on accept, empty on downstream take, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_colour;
            out_sof_d   = (expect_idx_q == 32'd0);
            out_eol_d   = x_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            width_q      <= '0;
            total_q      <= '0;
            last_core_q  <= '0;
            core_ptr_q   <= '0;
            expect_idx_q <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            idx_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            total_q      <= total_d;
            last_core_q  <= last_core_d;
            core_ptr_q   <= core_ptr_d;
            expect_idx_q <= expect_idx_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            idx_err_q    <= idx_err_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sof     = out_sof_q;
    assign out_eol     = out_eol_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_DONE);
    assign index_error = idx_err_q;
    assign state_dbg   = state_q;

endmodule
